// File: rtl/sram_2p_be_if.sv
// Request/response bundle of the two-port byte-maskable SRAM: one write port,
// one read port and the clear-engine status.
interface sram_2p_be_if #(
    parameter int DATA_WIDTH     = 128,
    parameter int ADDR_BIT_WIDTH = 7,
    parameter int BE_WIDTH       = DATA_WIDTH / 8
);
    logic                      i_wr_cs_n;
    logic [BE_WIDTH-1:0]       i_wr_be;
    logic [ADDR_BIT_WIDTH-1:0] i_wr_addr;
    logic [DATA_WIDTH-1:0]     i_wr_data;
    logic                      i_rd_cs_n;
    logic [ADDR_BIT_WIDTH-1:0] i_rd_addr;
    logic [DATA_WIDTH-1:0]     o_rd_data;
    logic                      o_rd_valid;
    logic                      o_init_busy;

    modport master (
        output i_wr_cs_n, i_wr_be, i_wr_addr, i_wr_data,
        output i_rd_cs_n, i_rd_addr,
        input  o_rd_data, o_rd_valid, o_init_busy
    );

    modport slave (
        input  i_wr_cs_n, i_wr_be, i_wr_addr, i_wr_data,
        input  i_rd_cs_n, i_rd_addr,
        output o_rd_data, o_rd_valid, o_init_busy
    );
endinterface

// File: rtl/sram_2p_be.sv
// Clocked two-port SRAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write result and a post-reset clear engine.
module sram_2p_be #(
    parameter int DATA_WIDTH     = 128,
    parameter int MAX_ADDR       = 128,
    parameter int ADDR_BIT_WIDTH = $clog2(MAX_ADDR),
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0
) (
    input logic         i_clk,
    input logic         i_rst_n,
    sram_2p_be_if.slave bus
);
    localparam logic [ADDR_BIT_WIDTH-1:0] LAST_ADDR = ADDR_BIT_WIDTH'(MAX_ADDR - 1);
    localparam logic [ADDR_BIT_WIDTH:0]   DEPTH     = (ADDR_BIT_WIDTH + 1)'(MAX_ADDR);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;
    logic [ADDR_BIT_WIDTH-1:0] clr_cnt_reg;
    logic [ADDR_BIT_WIDTH-1:0] clr_cnt_next;
    logic                      clr_last;
    logic                      clr_we;
    logic                      init_busy;

    logic                      wr_in_range;
    logic                      rd_in_range;
    logic                      wr_acc;
    logic                      rd_acc;
    logic                      rdw_hit;
    logic [ADDR_BIT_WIDTH-1:0] rd_index;

    logic                      mem_we;
    logic [ADDR_BIT_WIDTH-1:0] mem_waddr;
    logic [BE_WIDTH-1:0]       mem_wbe;
    logic [DATA_WIDTH-1:0]     mem_wdata;

    logic                      s1_valid_reg;
    logic                      s1_zero_reg;
    logic [DATA_WIDTH-1:0]     s1_data;

    // ---------------- clear-engine FSM ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= ST_CLEAR;
        end else begin
            state_reg <= state_next;
        end
    end

    assign clr_last = (clr_cnt_reg == LAST_ADDR);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CLEAR: if (clr_last) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_CLEAR;
        endcase
    end

    always_comb begin
        init_busy = 1'b0;
        clr_we    = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                init_busy = 1'b1;
                clr_we    = 1'b1;
            end
            default: begin
                init_busy = 1'b0;
                clr_we    = 1'b0;
            end
        endcase
    end

    assign clr_cnt_next = clr_we ? (clr_cnt_reg + ADDR_BIT_WIDTH'(1)) : clr_cnt_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            clr_cnt_reg <= '0;
        end else begin
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // ---------------- request acceptance ----------------
    assign wr_in_range = ({1'b0, bus.i_wr_addr} < DEPTH);
    assign rd_in_range = ({1'b0, bus.i_rd_addr} < DEPTH);
    assign wr_acc      = i_rst_n && !init_busy && !bus.i_wr_cs_n && wr_in_range;
    assign rd_acc      = i_rst_n && !init_busy && !bus.i_rd_cs_n;
    assign rdw_hit     = (RDW_MODE == 1) && wr_acc && (bus.i_wr_addr == bus.i_rd_addr);
    // Out-of-range reads still sample a legal word; the zero flag masks it.
    assign rd_index    = rd_in_range ? bus.i_rd_addr : '0;

    // Single write port shared by the clear engine and user writes; reset
    // itself never modifies the array.
    assign mem_we    = clr_we ? i_rst_n : wr_acc;
    assign mem_waddr = clr_we ? clr_cnt_reg : bus.i_wr_addr;
    assign mem_wbe   = clr_we ? {BE_WIDTH{1'b1}} : bus.i_wr_be;
    assign mem_wdata = clr_we ? '0 : bus.i_wr_data;

    // ---------------- storage, one byte lane per array ----------------
    generate
        for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
            logic [7:0] mem [0:MAX_ADDR-1];
            logic [7:0] rd_byte_reg;
            logic [7:0] fwd_byte_reg;
            logic       fwd_sel_reg;

            always_ff @(posedge i_clk) begin
                if (mem_we && mem_wbe[gi]) begin
                    mem[mem_waddr] <= mem_wdata[gi*8 +: 8];
                end
            end

            // Read-first array port; forwarding of the colliding write byte
            // is carried alongside so the array read stays a plain BRAM read.
            always_ff @(posedge i_clk) begin
                if (rd_acc) begin
                    rd_byte_reg  <= mem[rd_index];
                    fwd_sel_reg  <= rdw_hit && bus.i_wr_be[gi];
                    fwd_byte_reg <= bus.i_wr_data[gi*8 +: 8];
                end
            end

            assign s1_data[gi*8 +: 8] = s1_zero_reg  ? 8'h00 :
                                        fwd_sel_reg  ? fwd_byte_reg : rd_byte_reg;
        end
    endgenerate

    // Stage-1 control; registers only move on an accepted read so the
    // returned word holds between reads.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_zero_reg  <= 1'b1;
        end else begin
            s1_valid_reg <= rd_acc;
            if (rd_acc) begin
                s1_zero_reg <= !rd_in_range;
            end
        end
    end

    // ---------------- output latency ----------------
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s2_data_reg;
            logic                  s2_valid_reg;

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    s2_valid_reg <= 1'b0;
                    s2_data_reg  <= '0;
                end else begin
                    s2_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        s2_data_reg <= s1_data;
                    end
                end
            end

            assign bus.o_rd_data  = s2_data_reg;
            assign bus.o_rd_valid = s2_valid_reg;
        end else begin : g_lat1
            assign bus.o_rd_data  = s1_data;
            assign bus.o_rd_valid = s1_valid_reg;
        end
    endgenerate

    assign bus.o_init_busy = init_busy;
endmodule

// File: tb/tb_sram_2p_be.sv
// Scoreboard bench: two instances (128 words / latency 1 / old-data RDW and
// 100 words / latency 2 / new-data RDW) share one stimulus stream.
module tb_sram_2p_be;
    localparam int DW = 128;
    localparam int AW = 7;
    localparam int BW = DW / 8;

    localparam int MAX_D [2] = '{128, 100};
    localparam int LAT_D [2] = '{1, 2};
    localparam int RDW_D [2] = '{0, 1};

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wr_cs_n = 1'b1;
    logic [BW-1:0] wr_be   = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_cs_n = 1'b1;
    logic [AW-1:0] rd_addr = '0;

    always #5 clk = ~clk;

    sram_2p_be_if #(.DATA_WIDTH(DW), .ADDR_BIT_WIDTH(AW)) bus_a ();
    sram_2p_be_if #(.DATA_WIDTH(DW), .ADDR_BIT_WIDTH(AW)) bus_b ();

    assign bus_a.i_wr_cs_n = wr_cs_n;
    assign bus_a.i_wr_be   = wr_be;
    assign bus_a.i_wr_addr = wr_addr;
    assign bus_a.i_wr_data = wr_data;
    assign bus_a.i_rd_cs_n = rd_cs_n;
    assign bus_a.i_rd_addr = rd_addr;
    assign bus_b.i_wr_cs_n = wr_cs_n;
    assign bus_b.i_wr_be   = wr_be;
    assign bus_b.i_wr_addr = wr_addr;
    assign bus_b.i_wr_data = wr_data;
    assign bus_b.i_rd_cs_n = rd_cs_n;
    assign bus_b.i_rd_addr = rd_addr;

    sram_2p_be #(.DATA_WIDTH(DW), .MAX_ADDR(128), .RD_LATENCY(1), .RDW_MODE(0)) dut_a (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus_a)
    );

    sram_2p_be #(.DATA_WIDTH(DW), .MAX_ADDR(100), .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus_b)
    );

    logic [DW-1:0] mdl_mem  [2][128];
    bit            mdl_busy [2] = '{1'b1, 1'b1};
    int            mdl_cnt  [2] = '{0, 0};
    logic [DW-1:0] mdl_last [2] = '{'0, '0};
    int            busy_obs [2] = '{0, 0};
    exp_t          q_a [$];
    exp_t          q_b [$];
    int            edge_no = 0;
    int            n_err   = 0;
    int            n_chk   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %h, expected %h", tag, edge_no, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r = old_w;
        for (int k = 0; k < BW; k++) begin
            if (be[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
        end
        return r;
    endfunction

    // Applies the inputs currently driven to model d for the coming edge.
    task automatic model_edge(input int d);
        exp_t e;
        if (!rst_n) begin
            mdl_busy[d] = 1'b1;
            mdl_cnt[d]  = 0;
            mdl_last[d] = '0;
            busy_obs[d] = 0;
            if (d == 0) q_a.delete();
            else        q_b.delete();
        end else if (mdl_busy[d]) begin
            mdl_mem[d][mdl_cnt[d]] = '0;
            mdl_cnt[d]++;
            if (mdl_cnt[d] == MAX_D[d]) mdl_busy[d] = 1'b0;
        end else begin
            if (!rd_cs_n) begin
                e.due = edge_no + LAT_D[d] - 1;
                if (int'(rd_addr) >= MAX_D[d]) begin
                    e.data = '0;
                end else if (RDW_D[d] == 1 && !wr_cs_n && wr_addr == rd_addr) begin
                    e.data = merge(mdl_mem[d][rd_addr], wr_data, wr_be);
                end else begin
                    e.data = mdl_mem[d][rd_addr];
                end
                if (d == 0) q_a.push_back(e);
                else        q_b.push_back(e);
            end
            if (!wr_cs_n && int'(wr_addr) < MAX_D[d]) begin
                mdl_mem[d][wr_addr] = merge(mdl_mem[d][wr_addr], wr_data, wr_be);
            end
        end
    endtask

    task automatic observe(input int d);
        logic          v;
        logic          b;
        logic [DW-1:0] dat;
        exp_t          e;
        bit            due_now = 1'b0;
        string         nm = (d == 0) ? "A" : "B";
        if (d == 0) begin
            v = bus_a.o_rd_valid; dat = bus_a.o_rd_data; b = bus_a.o_init_busy;
            if (q_a.size() > 0 && q_a[0].due == edge_no) begin e = q_a.pop_front(); due_now = 1'b1; end
        end else begin
            v = bus_b.o_rd_valid; dat = bus_b.o_rd_data; b = bus_b.o_init_busy;
            if (q_b.size() > 0 && q_b[0].due == edge_no) begin e = q_b.pop_front(); due_now = 1'b1; end
        end
        check({nm, " init_busy"}, DW'(b), DW'(mdl_busy[d]));
        if (b) busy_obs[d]++;
        if (due_now) begin
            check({nm, " rd_valid"}, DW'(v), DW'(1'b1));
            check({nm, " rd_data"}, dat, e.data);
            mdl_last[d] = e.data;
            $display("read %s edge %0d data %h", nm, edge_no, dat);
        end else begin
            check({nm, " rd_valid idle"}, DW'(v), DW'(1'b0));
            check({nm, " rd_data hold"}, dat, mdl_last[d]);
        end
    endtask

    task automatic cycle(input bit rst_v, input bit wr_v, input logic [BW-1:0] be_v,
                         input logic [AW-1:0] wa_v, input logic [DW-1:0] wd_v,
                         input bit rd_v, input logic [AW-1:0] ra_v);
        @(negedge clk);
        rst_n   = rst_v;
        wr_cs_n = !wr_v;
        wr_be   = be_v;
        wr_addr = wa_v;
        wr_data = wd_v;
        rd_cs_n = !rd_v;
        rd_addr = ra_v;
        edge_no++;
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        observe(0);
        observe(1);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic rst_cycles(input int n);
        repeat (n) cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] dat, input logic [BW-1:0] be);
        cycle(1'b1, 1'b1, be, a, dat, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cycle(1'b1, 1'b0, '0, '0, '0, 1'b1, a);
    endtask

    task automatic wrrd(input logic [AW-1:0] wa, input logic [DW-1:0] dat,
                        input logic [BW-1:0] be, input logic [AW-1:0] ra);
        cycle(1'b1, 1'b1, be, wa, dat, 1'b1, ra);
    endtask

    task automatic check_clear_len();
        check("A clear length", DW'(busy_obs[0]), DW'(128));
        check("B clear length", DW'(busy_obs[1]), DW'(100));
    endtask

    initial begin
        rst_cycles(2);
        idle(130);
        check_clear_len();

        // Fill with 0xA5, then reset: the clear engine must wipe it.
        wr(7'd0,   {16{8'hA5}}, '1);
        wr(7'd64,  {16{8'hA5}}, '1);
        wr(7'd127, {16{8'hA5}}, '1);
        rd(7'd0); rd(7'd64); rd(7'd127);
        idle(3);
        rst_cycles(1);
        idle(130);
        check_clear_len();
        rd(7'd0); rd(7'd64); rd(7'd127);
        idle(3);

        // Byte mask, including an all-zero mask.
        wr(7'd10, 128'h00112233445566778899AABBCCDDEEFF, '1);
        wr(7'd10, {16{8'hEE}}, 16'h00F0);
        rd(7'd10);
        wr(7'd10, {16{8'h55}}, 16'h0000);
        rd(7'd10);
        idle(3);

        // Same-edge read/write collisions.
        wr(7'd5, 128'h1, '1);
        wrrd(7'd5, 128'h2, '1, 7'd5);
        rd(7'd5);
        wrrd(7'd6, {16{8'h77}}, 16'h8001, 7'd6);
        rd(7'd6);
        idle(3);

        // Back-to-back streaming.
        for (int i = 0; i < 10; i++) wr(AW'(i), {4{32'hD0D0_0000 + 32'(i)}}, '1);
        for (int i = 0; i < 10; i++) rd(AW'(i));
        idle(4);

        // Range boundaries (B holds 100 words, A holds 128).
        wr(7'd99,  {16{8'h99}}, '1);
        wr(7'd100, {16{8'h10}}, '1);
        wr(7'd110, {16{8'h6E}}, '1);
        wr(7'd127, {16{8'h7F}}, '1);
        rd(7'd99); rd(7'd100); rd(7'd110); rd(7'd127);
        wrrd(7'd100, {16{8'h42}}, '1, 7'd100);
        idle(4);

        // Requests during the clear, including the last clear edge and the first ready edge.
        rst_cycles(1);
        for (int i = 0; i < 140; i++) begin
            if (i == 50)
                wrrd(7'd3, {16{8'h3C}}, '1, 7'd3);
            else if (i == 99 || i == 100 || i == 127 || i == 128)
                wrrd(7'd4, {4{32'hB00C_0000 + 32'(i)}}, '1, 7'd4);
            else
                idle(1);
        end
        rd(7'd3); rd(7'd4);
        idle(4);

        // Reset right behind a read.
        rd(7'd4);
        rst_cycles(1);
        idle(130);
        check_clear_len();
        rd(7'd4);
        idle(4);

        check("A queue drained", DW'(q_a.size()), '0);
        check("B queue drained", DW'(q_b.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
